// File: rtl/reg_alloc_ctrl.sv
// reg_alloc_ctrl: register allocation unit controller.
// Hands out physical register blocks to warps, reclaims them on warp exit,
// and translates (warp, logical register) into physical rows for two OC ports.
// Optional macro RAU_BOUND_CHECK_EN: flags reads beyond a warp's allocated blocks.
module reg_alloc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       AlloEN_TM_RAU,
    input  logic [2:0] HWWarp_TM_RAU,
    input  logic [2:0] Nreq_TM_RAU,
    input  logic [7:0] SWWarp_TM_RAU,
    output logic       Ready_RAU_TM,
    output logic       AlloAck_RAU_TM,
    output logic       AlloErr_RAU_TM,
    output logic       AlloDone_RAU_TM,
    output logic [7:0] DoneSWWarp_RAU_TM,
    output logic [4:0] Available_RAU_TM,
    output logic [7:0] AllocStall_RAU_IB,
    input  logic       Exit_IB_RAU_TM,
    input  logic [2:0] Exit_WarpID_IB_RAU_TM,
    input  logic       RdEn1_OC_RAU,
    input  logic       RdEn2_OC_RAU,
    input  logic [2:0] RdWarp1_OC_RAU,
    input  logic [2:0] RdWarp2_OC_RAU,
    input  logic [3:0] RdReg1_OC_RAU,
    input  logic [3:0] RdReg2_OC_RAU,
    output logic [5:0] RdPhys1_RAU_OC,
    output logic [5:0] RdPhys2_RAU_OC,
    output logic       RdValid1_RAU_OC,
    output logic       RdValid2_RAU_OC,
    output logic       RdFault1_RAU_OC,
    output logic       RdFault2_RAU_OC
);
    localparam int NUM_WARPS  = 8;
    localparam int NUM_BLOCKS = 16;
    localparam int MAX_BLK    = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ALLOC, ST_FREE} state_t;

    state_t state, next_state;

    logic [NUM_WARPS-1:0]  mapped, pending, pending_next, exit_mask;
    logic [2:0]            nblk    [NUM_WARPS];
    logic [3:0]            blk_map [NUM_WARPS][MAX_BLK];
    logic [NUM_BLOCKS-1:0] free_map;
    logic [4:0]            avail;
    logic [2:0]            cur_warp, cur_nreq, cnt, cnt_inc;
    logic [7:0]            cur_sw;
    logic [3:0]            free_blk;
    logic [2:0]            free_warp;
    logic                  req_bad, accept, reject, start_free;
    logic                  alloc_step, alloc_last, free_step, free_last;

    logic [1:0] rq_en;
    logic [2:0] rq_warp [2];
    logic [3:0] rq_reg  [2];
    logic [1:0] x_hit, x_fault, x_valid;
    logic [5:0] x_phys  [2];

    assign Ready_RAU_TM     = (state == ST_IDLE) && (pending == '0);
    assign Available_RAU_TM = avail;
    assign cnt_inc          = cnt + 3'd1;

    // Qualify an exit strobe: only warps that own (or are acquiring) blocks become pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        exit_mask = '0;
        if (Exit_IB_RAU_TM &&
            (mapped[Exit_WarpID_IB_RAU_TM] ||
             (state == ST_ALLOC && cur_warp == Exit_WarpID_IB_RAU_TM)))
            exit_mask[Exit_WarpID_IB_RAU_TM] = 1'b1;
    end

    // Lowest-index free block and lowest-index pending warp (including a same-cycle exit).
    always_comb begin
        free_blk  = '0;
        free_warp = '0;
        for (int b = NUM_BLOCKS - 1; b >= 0; b--)
            if (free_map[b]) free_blk = 4'(b);
        for (int w = NUM_WARPS - 1; w >= 0; w--)
            if (pending[w] || exit_mask[w]) free_warp = 3'(w);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        start_free = 1'b0;
        alloc_step = 1'b0;
        alloc_last = 1'b0;
        free_step  = 1'b0;
        free_last  = 1'b0;
        req_bad    = (Nreq_TM_RAU == 3'd0) || (Nreq_TM_RAU > 3'(MAX_BLK)) ||
                     ({2'b00, Nreq_TM_RAU} > avail) || mapped[HWWarp_TM_RAU];
        case (state)
            ST_IDLE: begin
                if ((pending | exit_mask) != '0) begin
                    start_free = 1'b1;
                    next_state = ST_FREE;
                end else if (AlloEN_TM_RAU) begin
                    if (req_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        next_state = ST_ALLOC;
                    end
                end
            end
            ST_ALLOC: begin
                alloc_step = 1'b1;
                if (cnt_inc == cur_nreq) begin
                    alloc_last = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_FREE: begin
                free_step = 1'b1;
                if (cnt_inc == nblk[cur_warp]) begin
                    free_last  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Pending-exit update: new exits set, completion of a free clears.
    always_comb begin
        pending_next = pending | exit_mask;
        if (free_last) pending_next[cur_warp] = 1'b0;
    end

    // Allocation tables, free bitmap, counters and TM/IB handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mapped            <= '0;
            pending           <= '0;
            free_map          <= '1;
            avail             <= 5'(NUM_BLOCKS);
            cur_warp          <= '0;
            cur_nreq          <= '0;
            cur_sw            <= '0;
            cnt               <= '0;
            AlloAck_RAU_TM    <= 1'b0;
            AlloErr_RAU_TM    <= 1'b0;
            AlloDone_RAU_TM   <= 1'b0;
            DoneSWWarp_RAU_TM <= '0;
            AllocStall_RAU_IB <= '1;
            // NOTE: the map table is small and cleared on reset so no stale block IDs survive.
            for (int w = 0; w < NUM_WARPS; w++) begin
                nblk[w] <= '0;
                for (int k = 0; k < MAX_BLK; k++) blk_map[w][k] <= '0;
            end
        end else begin
            AlloAck_RAU_TM  <= accept;
            AlloErr_RAU_TM  <= reject;
            AlloDone_RAU_TM <= alloc_last;
            pending         <= pending_next;
            if (accept) begin
                cur_warp <= HWWarp_TM_RAU;
                cur_nreq <= Nreq_TM_RAU;
                cur_sw   <= SWWarp_TM_RAU;
                cnt      <= '0;
            end
            if (start_free) begin
                cur_warp                     <= free_warp;
                cnt                          <= '0;
                mapped[free_warp]            <= 1'b0;
                AllocStall_RAU_IB[free_warp] <= 1'b1;
            end
            if (alloc_step) begin
                blk_map[cur_warp][cnt[1:0]] <= free_blk;
                free_map[free_blk]          <= 1'b0;
                avail                       <= avail - 5'd1;
                cnt                         <= cnt_inc;
            end
            if (alloc_last) begin
                mapped[cur_warp]            <= 1'b1;
                nblk[cur_warp]              <= cur_nreq;
                DoneSWWarp_RAU_TM           <= cur_sw;
                AllocStall_RAU_IB[cur_warp] <= 1'b0;
            end
            if (free_step) begin
                free_map[blk_map[cur_warp][cnt[1:0]]] <= 1'b1;
                avail                                 <= avail + 5'd1;
                cnt                                   <= cnt_inc;
            end
        end
    end

    assign rq_en      = {RdEn2_OC_RAU, RdEn1_OC_RAU};
    assign rq_warp[0] = RdWarp1_OC_RAU;
    assign rq_warp[1] = RdWarp2_OC_RAU;
    assign rq_reg[0]  = RdReg1_OC_RAU;
    assign rq_reg[1]  = RdReg2_OC_RAU;

    // Combinational translation for both read ports against the current (pre-edge) table.
    always_comb begin
        x_hit   = '0;
        x_fault = '0;
        x_valid = '0;
        for (int p = 0; p < 2; p++) begin
            x_hit[p] = rq_en[p] && mapped[rq_warp[p]];
`ifdef RAU_BOUND_CHECK_EN
            x_fault[p] = x_hit[p] && ({1'b0, rq_reg[p][3:2]} >= nblk[rq_warp[p]]);
`else
            x_fault[p] = 1'b0;
`endif
            x_valid[p] = x_hit[p] && !x_fault[p];
            x_phys[p]  = x_valid[p] ? {blk_map[rq_warp[p]][rq_reg[p][3:2]], rq_reg[p][1:0]} : 6'd0;
        end
    end

    // Register translation results (one-cycle latency per port).
    always_ff @(posedge clk) begin
        if (!rst) begin
            RdValid1_RAU_OC <= 1'b0;
            RdValid2_RAU_OC <= 1'b0;
            RdFault1_RAU_OC <= 1'b0;
            RdFault2_RAU_OC <= 1'b0;
            RdPhys1_RAU_OC  <= '0;
            RdPhys2_RAU_OC  <= '0;
        end else begin
            RdValid1_RAU_OC <= x_valid[0];
            RdValid2_RAU_OC <= x_valid[1];
            RdFault1_RAU_OC <= x_fault[0];
            RdFault2_RAU_OC <= x_fault[1];
            RdPhys1_RAU_OC  <= x_phys[0];
            RdPhys2_RAU_OC  <= x_phys[1];
        end
    end

endmodule

// File: tb/tb_reg_alloc_ctrl.sv
// Self-checking bench for reg_alloc_ctrl: directed scenarios then random
// alloc/exit/read traffic against a block-pool reference model.
module tb_reg_alloc_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       AlloEN_TM_RAU = 1'b0;
    logic [2:0] HWWarp_TM_RAU = '0;
    logic [2:0] Nreq_TM_RAU = '0;
    logic [7:0] SWWarp_TM_RAU = '0;
    logic       Ready_RAU_TM, AlloAck_RAU_TM, AlloErr_RAU_TM, AlloDone_RAU_TM;
    logic [7:0] DoneSWWarp_RAU_TM;
    logic [4:0] Available_RAU_TM;
    logic [7:0] AllocStall_RAU_IB;
    logic       Exit_IB_RAU_TM = 1'b0;
    logic [2:0] Exit_WarpID_IB_RAU_TM = '0;
    logic       RdEn1_OC_RAU = 1'b0, RdEn2_OC_RAU = 1'b0;
    logic [2:0] RdWarp1_OC_RAU = '0, RdWarp2_OC_RAU = '0;
    logic [3:0] RdReg1_OC_RAU = '0, RdReg2_OC_RAU = '0;
    logic [5:0] RdPhys1_RAU_OC, RdPhys2_RAU_OC;
    logic       RdValid1_RAU_OC, RdValid2_RAU_OC, RdFault1_RAU_OC, RdFault2_RAU_OC;

    reg_alloc_ctrl dut (
        .clk(clk), .rst(rst),
        .AlloEN_TM_RAU(AlloEN_TM_RAU), .HWWarp_TM_RAU(HWWarp_TM_RAU),
        .Nreq_TM_RAU(Nreq_TM_RAU), .SWWarp_TM_RAU(SWWarp_TM_RAU),
        .Ready_RAU_TM(Ready_RAU_TM), .AlloAck_RAU_TM(AlloAck_RAU_TM),
        .AlloErr_RAU_TM(AlloErr_RAU_TM), .AlloDone_RAU_TM(AlloDone_RAU_TM),
        .DoneSWWarp_RAU_TM(DoneSWWarp_RAU_TM), .Available_RAU_TM(Available_RAU_TM),
        .AllocStall_RAU_IB(AllocStall_RAU_IB),
        .Exit_IB_RAU_TM(Exit_IB_RAU_TM), .Exit_WarpID_IB_RAU_TM(Exit_WarpID_IB_RAU_TM),
        .RdEn1_OC_RAU(RdEn1_OC_RAU), .RdEn2_OC_RAU(RdEn2_OC_RAU),
        .RdWarp1_OC_RAU(RdWarp1_OC_RAU), .RdWarp2_OC_RAU(RdWarp2_OC_RAU),
        .RdReg1_OC_RAU(RdReg1_OC_RAU), .RdReg2_OC_RAU(RdReg2_OC_RAU),
        .RdPhys1_RAU_OC(RdPhys1_RAU_OC), .RdPhys2_RAU_OC(RdPhys2_RAU_OC),
        .RdValid1_RAU_OC(RdValid1_RAU_OC), .RdValid2_RAU_OC(RdValid2_RAU_OC),
        .RdFault1_RAU_OC(RdFault1_RAU_OC), .RdFault2_RAU_OC(RdFault2_RAU_OC)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: which blocks each warp owns, in allocation order.
    bit         m_mapped [8];
    int         m_blk    [8][$];
    bit         m_free   [16];
    int         m_avail;
    logic [7:0] m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int w = 0; w < 8; w++) begin
            m_mapped[w] = 1'b0;
            m_blk[w].delete();
        end
        for (int b = 0; b < 16; b++) m_free[b] = 1'b1;
        m_avail = 16;
        m_stall = 8'hFF;
    endtask

    task automatic model_take(input int w, input int n);
        m_blk[w].delete();
        for (int b = 0; b < 16 && m_blk[w].size() < n; b++)
            if (m_free[b]) begin
                m_blk[w].push_back(b);
                m_free[b] = 1'b0;
            end
        m_avail    -= n;
        m_mapped[w] = 1'b1;
        m_stall[w]  = 1'b0;
    endtask

    task automatic model_release(input int w);
        foreach (m_blk[w][k]) m_free[m_blk[w][k]] = 1'b1;
        m_avail    += m_blk[w].size();
        m_blk[w].delete();
        m_mapped[w] = 1'b0;
        m_stall[w]  = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        check("rst_ready", Ready_RAU_TM, 1);
        check("rst_avail", Available_RAU_TM, 16);
        check("rst_stall", AllocStall_RAU_IB, 8'hFF);
        check("rst_pulses", {AlloAck_RAU_TM, AlloErr_RAU_TM, AlloDone_RAU_TM}, 0);
        check("rst_doneswwarp", DoneSWWarp_RAU_TM, 0);
        check("rst_rd", {RdValid1_RAU_OC, RdValid2_RAU_OC, RdFault1_RAU_OC, RdFault2_RAU_OC,
                         RdPhys1_RAU_OC, RdPhys2_RAU_OC}, 0);
    endtask

    task automatic wait_ready(input int budget, output int cycles);
        cycles = 0;
        while (Ready_RAU_TM !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        check("ready_wait", Ready_RAU_TM, 1);
    endtask

    task automatic do_alloc(input int w, input int n, input logic [7:0] sw);
        bit ok;
        ok = (n >= 1) && (n <= 4) && (n <= m_avail) && !m_mapped[w];
        AlloEN_TM_RAU = 1'b1;
        HWWarp_TM_RAU = 3'(w);
        Nreq_TM_RAU   = 3'(n);
        SWWarp_TM_RAU = sw;
        tick();
        AlloEN_TM_RAU = 1'b0;
        check("alloc_ack", AlloAck_RAU_TM, ok);
        check("alloc_err", AlloErr_RAU_TM, !ok);
        if (ok) begin
            repeat (n - 1) tick();
            check("done_early", AlloDone_RAU_TM, 0);
            tick();
            check("done_pulse", AlloDone_RAU_TM, 1);
            check("done_swwarp", DoneSWWarp_RAU_TM, sw);
            model_take(w, n);
            check("alloc_stall", AllocStall_RAU_IB, m_stall);
        end else begin
            check("err_ready", Ready_RAU_TM, 1);
        end
        check("alloc_avail", Available_RAU_TM, m_avail);
    endtask

    task automatic do_exit(input int w);
        int n, cyc;
        Exit_IB_RAU_TM        = 1'b1;
        Exit_WarpID_IB_RAU_TM = 3'(w);
        tick();
        Exit_IB_RAU_TM = 1'b0;
        if (m_mapped[w]) begin
            n = m_blk[w].size();
            check("exit_ready_low", Ready_RAU_TM, 0);
            model_release(w);
            check("exit_stall", AllocStall_RAU_IB, m_stall);
            wait_ready(20, cyc);
            check("free_cycles", cyc, n);
        end else begin
            check("exit_dropped", Ready_RAU_TM, 1);
        end
        check("exit_avail", Available_RAU_TM, m_avail);
    endtask

    task automatic xlate_exp(input int w, input int r, output logic v, output logic f,
                             output logic [5:0] ph, output bit known);
        int idx;
        idx   = r / 4;
        known = 1'b1;
`ifdef RAU_BOUND_CHECK_EN
        f = m_mapped[w] && (idx >= m_blk[w].size());
        v = m_mapped[w] && !f;
        ph = v ? 6'(m_blk[w][idx] * 4 + r % 4) : 6'd0;
`else
        f = 1'b0;
        v = m_mapped[w];
        if (!m_mapped[w]) ph = 6'd0;
        else if (idx < m_blk[w].size()) ph = 6'(m_blk[w][idx] * 4 + r % 4);
        else begin
            ph    = 6'd0;
            known = 1'b0;
        end
`endif
    endtask

    task automatic do_read(input int w1, input int r1, input int w2, input int r2);
        logic v, f;
        logic [5:0] ph;
        bit known;
        RdEn1_OC_RAU = 1'b1; RdWarp1_OC_RAU = 3'(w1); RdReg1_OC_RAU = 4'(r1);
        RdEn2_OC_RAU = 1'b1; RdWarp2_OC_RAU = 3'(w2); RdReg2_OC_RAU = 4'(r2);
        tick();
        RdEn1_OC_RAU = 1'b0;
        RdEn2_OC_RAU = 1'b0;
        xlate_exp(w1, r1, v, f, ph, known);
        check("rd1_valid", RdValid1_RAU_OC, v);
        check("rd1_fault", RdFault1_RAU_OC, f);
        if (known) check("rd1_phys", RdPhys1_RAU_OC, ph);
        xlate_exp(w2, r2, v, f, ph, known);
        check("rd2_valid", RdValid2_RAU_OC, v);
        check("rd2_fault", RdFault2_RAU_OC, f);
        if (known) check("rd2_phys", RdPhys2_RAU_OC, ph);
    endtask

    initial begin
        int cyc;
        do_reset();

        // First allocation: warp 3, two blocks, tag 5A.
        do_alloc(3, 2, 8'h5A);
        check("plan_stall_f7", AllocStall_RAU_IB, 8'hF7);
        check("plan_avail_14", Available_RAU_TM, 14);
        do_read(3, 6, 5, 0);
        check("plan_phys_6", RdPhys1_RAU_OC, 6);
        check("plan_unmapped", RdValid2_RAU_OC, 0);
        do_exit(3);

        // Exhaust the pool, then rejections.
        for (int w = 0; w < 4; w++) do_alloc(w, 4, 8'(8'h10 + w));
        check("pool_empty", Available_RAU_TM, 0);
        do_alloc(4, 1, 8'h44);
        do_alloc(4, 5, 8'h45);
        do_alloc(4, 0, 8'h46);
        do_alloc(0, 1, 8'h47);

        // Exit of warp 1 while warp 2 is being allocated.
        do_exit(2);
        AlloEN_TM_RAU = 1'b1; HWWarp_TM_RAU = 3'd2; Nreq_TM_RAU = 3'd4; SWWarp_TM_RAU = 8'hC2;
        tick();
        AlloEN_TM_RAU = 1'b0;
        check("ovl_ack", AlloAck_RAU_TM, 1);
        Exit_IB_RAU_TM = 1'b1; Exit_WarpID_IB_RAU_TM = 3'd1;
        tick();
        Exit_IB_RAU_TM = 1'b0;
        repeat (2) tick();
        check("ovl_done_early", AlloDone_RAU_TM, 0);
        tick();
        check("ovl_done", AlloDone_RAU_TM, 1);
        check("ovl_doneswwarp", DoneSWWarp_RAU_TM, 8'hC2);
        model_take(2, 4);
        check("ovl_pending_ready", Ready_RAU_TM, 0);
        wait_ready(20, cyc);
        check("ovl_free_cycles", cyc, 5);
        model_release(1);
        check("ovl_avail", Available_RAU_TM, 4);
        do_alloc(5, 4, 8'h55);
        do_read(5, 0, 5, 15);
        check("w5_first_block", RdPhys1_RAU_OC, 16);
        check("w5_last_block", RdPhys2_RAU_OC, 31);

        // Exit and allocation request in the same idle cycle.
        Exit_IB_RAU_TM = 1'b1; Exit_WarpID_IB_RAU_TM = 3'd0;
        AlloEN_TM_RAU = 1'b1; HWWarp_TM_RAU = 3'd6; Nreq_TM_RAU = 3'd1;
        tick();
        Exit_IB_RAU_TM = 1'b0;
        AlloEN_TM_RAU  = 1'b0;
        check("same_cycle_ack", AlloAck_RAU_TM, 0);
        check("same_cycle_err", AlloErr_RAU_TM, 0);
        check("same_cycle_ready", Ready_RAU_TM, 0);
        model_release(0);
        wait_ready(20, cyc);
        check("same_cycle_free_cycles", cyc, 4);
        check("same_cycle_avail", Available_RAU_TM, m_avail);
        do_read(6, 0, 0, 0);

        // Reset in the middle of an allocation.
        AlloEN_TM_RAU = 1'b1; HWWarp_TM_RAU = 3'd6; Nreq_TM_RAU = 3'd3;
        tick();
        AlloEN_TM_RAU = 1'b0;
        check("midrst_ack", AlloAck_RAU_TM, 1);
        tick();
        do_reset();

        // Bound check on a one-block warp.
        do_alloc(7, 1, 8'h77);
        do_read(7, 5, 7, 1);
`ifdef RAU_BOUND_CHECK_EN
        check("bound_fault", RdFault1_RAU_OC, 1);
        check("bound_valid", RdValid1_RAU_OC, 0);
`else
        check("bound_fault", RdFault1_RAU_OC, 0);
        check("bound_valid", RdValid1_RAU_OC, 1);
`endif

        // Random traffic.
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 2))
                0: do_alloc(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)), 8'($urandom));
                1: do_exit(int'($urandom_range(0, 7)));
                default: do_read(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_alloc_ctrl.md
Name: reg_alloc_ctrl

Overview:
- Register allocation unit (RAU) controller for the shared operand-collector register file.
- Owns a pool of physical register blocks and allocates them to hardware warps on Task Manager (TM) request.
- Frees a warp's blocks on warp exit from the Instruction Buffer (IB).
- Translates (warp, logical register) to a physical register-file row for the operand collector (OC) read ports.

Parameters:
- NUM_WARPS, 8: hardware warps; warp ID width is 3.
- NUM_BLOCKS, 16: physical register blocks in the pool.
- REGS_PER_BLOCK, 4: registers per block. Physical row = block*4 + offset, 64 rows, 6 bits.
- MAX_BLK, 4: maximum blocks per warp; logical register space is 16 registers, 4 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- AlloEN_TM_RAU  in  1  allocation request strobe
- HWWarp_TM_RAU  in  3  warp to allocate
- Nreq_TM_RAU  in  3  blocks requested
- SWWarp_TM_RAU  in  8  software warp tag, echoed on done
- Ready_RAU_TM  out  1  controller idle, can accept a request
- AlloAck_RAU_TM  out  1  request accepted, 1-cycle pulse
- AlloErr_RAU_TM  out  1  request rejected, 1-cycle pulse
- AlloDone_RAU_TM  out  1  allocation complete, 1-cycle pulse
- DoneSWWarp_RAU_TM  out  8  SWWarp of the completed allocation
- Available_RAU_TM  out  5  free block count
- AllocStall_RAU_IB  out  8  per-warp stall; 1 = warp has no usable mapping
- Exit_IB_RAU_TM  in  1  warp exit strobe
- Exit_WarpID_IB_RAU_TM  in  3  exiting warp
- RdEn1_OC_RAU, RdEn2_OC_RAU  in  1 each  translation request
- RdWarp1_OC_RAU, RdWarp2_OC_RAU  in  3 each  warp
- RdReg1_OC_RAU, RdReg2_OC_RAU  in  4 each  logical register
- RdPhys1_RAU_OC, RdPhys2_RAU_OC  out  6 each  physical row
- RdValid1_RAU_OC, RdValid2_RAU_OC  out  1 each  translation valid
- RdFault1_RAU_OC, RdFault2_RAU_OC  out  1 each  out-of-range access

Behaviour:
- State per warp: mapped flag, nblk[2:0], map[0..3] block IDs (4 bits each). Global state: free bitmap (16 bits), pending-exit vector (8 bits).
- Reset (rst=0 at posedge) clears:
  - all mapped flags, nblk, map entries, pending vector;
  - bitmap = all free; Available = 16; FSM = IDLE;
  - AllocStall = 8'hFF; every pulse, Rd* and DoneSWWarp output = 0.
- Reset mid-operation abandons any allocation or free in progress.
- FSM states are IDLE, ALLOC and FREE. Ready = (state==IDLE) && (pending==0).
- Exit capture, every cycle in any state:
  - Exit_IB_RAU_TM sets pending[Exit_WarpID_IB_RAU_TM].
  - Exit of an unmapped warp that is also not being allocated is dropped.
- IDLE:
  - If pending != 0, go to FREE for the lowest pending warp. Exit has priority over an AlloEN in the same cycle, which is ignored.
  - Otherwise, AlloEN is rejected (AlloErr pulse, no state change) if Nreq==0, Nreq>MAX_BLK, Nreq>Available, or the warp is already mapped.
  - Otherwise AlloEN is accepted: AlloAck pulse next cycle; latch warp, Nreq and SWWarp; counter i=0; go to ALLOC.
- AlloEN while Ready=0 is ignored: no Ack and no Err.
- ALLOC, one block per cycle:
  - Lowest-index free block b is written to map[warp][i]; bitmap[b] cleared; Available decremented; i incremented.
  - In the cycle i reaches Nreq: set mapped and nblk; pulse AlloDone with DoneSWWarp; clear AllocStall[warp] on the same edge; return to IDLE.
  - Latency from accept to Done is Nreq+1 cycles.
- FREE, for warp w:
  - First cycle: set AllocStall[w]=1 and clear mapped[w].
  - Then one block per cycle: bitmap set, Available incremented.
  - After nblk blocks: clear pending[w], return to IDLE.
  - An exit for a warp currently in ALLOC stays pending and is freed after ALLOC completes.
- Available never exceeds 16 or underflows. Available equals the popcount of the bitmap at all times.
- Translation, 1-cycle registered latency per port:
  - RdValid = RdEn && mapped[warp].
  - RdPhys = map[warp][reg[3:2]]*4 + reg[1:0]; 0 when not valid.
  - The two ports are independent, and a same-cycle identical request gives identical results.
  - A translation in the same cycle as a mapping change uses the pre-edge table.

Optional Feature:
- Macro RAU_BOUND_CHECK_EN.
- Defined: RdFault = RdEn && mapped && (reg[3:2] >= nblk). When RdFault=1, RdValid=0 and RdPhys=0.
- Undefined: RdFault tied 0; RdValid ignores the bound; RdPhys uses whatever map entry is indexed.

Test Plan:
- Reset, then alloc warp 3 with Nreq=2 and SWWarp=8'h5A -> Ack at T+1, Done at T+3 with DoneSWWarp=5A, map={0,1}, Available=14, AllocStall=8'hF7.
- Warp 3 mapped {0,1}, read port 1 with warp=3, reg=4'd6 -> next cycle RdValid1=1, RdPhys1=6'd6. Warp 5 unmapped, read port 2 -> RdValid2=0.
- Allocate warps 0..3 with 4 blocks each, then alloc warp 4 with Nreq=1 -> Available=0, AlloErr pulse, no state change. Nreq=5 also gives AlloErr.
- Exit warp 1 (blocks 4..7) during an ALLOC of warp 2 -> pending held. After Done, FREE runs 4 cycles and Available rises by 4. A subsequent alloc with Nreq=4 gets blocks 4..7.
- Exit and AlloEN in the same IDLE cycle -> exit processed, request ignored (no Ack/Err), Ready low until FREE ends.
- With RAU_BOUND_CHECK_EN, warp with nblk=1 reads reg 4'd5 -> RdFault=1, RdValid=0. Without the macro -> RdFault=0, RdValid=1.
